// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state encoding and operation-mode constants for seq_muldiv
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;
endpackage

// File: rtl/add_rca_n.sv
// add_rca_n: N-bit ripple-carry adder with carry-in; subtract by feeding ~b and c_i=1
module add_rca_n #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o
);
  logic [N-1:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    if (i < N - 1) begin : g_carry
      assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end
endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative signed multiply (shift-add) / divide (restoring) on magnitudes,
// one iteration per cycle, sign-corrected in a final FIX cycle.
module seq_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 muordi,
  input  logic [WIDTH-1:0]     opera1,
  input  logic [WIDTH-1:0]     opera2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 valid,
  output logic                 busy,
  output logic                 div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic mode_q, s1_q, s2_q, zero_q;
  logic [WIDTH-1:0] a_q, acc_q, lo_q, acc_d, lo_d, mag1, mag2, mul_b, quo_f, rem_f;
  logic [WIDTH:0] add_a, add_b, sum;
  logic [2*WIDTH-1:0] prod, res_d;
  assign mag1 = opera1[WIDTH-1] ? -opera1 : opera1;
  assign mag2 = opera2[WIDTH-1] ? -opera2 : opera2;
  // acc_q holds the high product half (mul) or the partial remainder (div); lo_q the multiplier / dividend-quotient
  always_comb begin
    mul_b = lo_q[0] ? a_q : '0;
    add_a = (mode_q == MODE_DIV) ? {acc_q, lo_q[WIDTH-1]} : {1'b0, acc_q};
    add_b = (mode_q == MODE_DIV) ? ~{1'b0, a_q} : {1'b0, mul_b};
    acc_d = (mode_q == MODE_DIV) ? (sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0]) : sum[WIDTH:1];
    lo_d  = (mode_q == MODE_DIV) ? {lo_q[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
    prod  = {acc_q, lo_q};
    quo_f = zero_q ? '1 : ((s1_q ^ s2_q) ? -lo_q : lo_q);
    rem_f = s2_q ? -acc_q : acc_q;
    res_d = (mode_q == MODE_DIV) ? {rem_f, quo_f} : ((s1_q ^ s2_q) ? -prod : prod);
  end
  add_rca_n #(.N(WIDTH + 1)) u_add (
    .a_i(add_a),
    .b_i(add_b),
    .c_i(mode_q == MODE_DIV),
    .s_o(sum)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_MUL;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      zero_q      <= 1'b0;
      a_q         <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      result      <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          mode_q  <= muordi;
          s1_q    <= opera1[WIDTH-1];
          s2_q    <= opera2[WIDTH-1];
          zero_q  <= muordi & (opera1 == '0);
          a_q     <= mag1;
          acc_q   <= '0;
          lo_q    <= mag2;
          cnt_q   <= '0;
          busy    <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          acc_q   <= acc_d;
          lo_q    <= lo_d;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == LAST) ? FIX : CALC;
        end
        FIX: begin
          result      <= res_d;
          valid       <= 1'b1;
          div_by_zero <= zero_q;
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: directed + random checks of seq_muldiv (WIDTH=32) against a 64-bit arithmetic model
module tb_seq_muldiv;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, muordi = 1'b0;
  logic [31:0] opera1 = '0, opera2 = '0;
  logic [63:0] result;
  logic valid, busy, div_by_zero;
  int nvec = 0, nerr = 0;
  logic [63:0] res;
  logic dbz, busy_ok, saw_valid;
  int lat;

  seq_muldiv #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .muordi(muordi),
    .opera1(opera1), .opera2(opera2), .result(result), .valid(valid),
    .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!m) return 64'(sa * sb);
    if (a == 32'd0) return {b, 32'hFFFF_FFFF};
    return {32'(sb % sa), 32'(sb / sa)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation at posedge+1; scrambles operands and pulses start mid-operation.
  task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; muordi = m; opera1 = a; opera2 = b;
    @(posedge clock); #1;
    lat = 0;
    busy_ok = busy;
    while (!valid && lat < 100) begin
      start = (lat == 4);
      opera1 = $urandom; opera2 = $urandom; muordi = 1'($urandom);
      @(posedge clock); #1;
      lat++;
      if (!valid && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    res = result;
    dbz = div_by_zero;
  endtask

  task automatic op_chk(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b);
    do_op(m, a, b);
    chk({tag, " result"}, res, model(m, a, b));
    chk({tag, " lat/busy"}, {lat, busy_ok, busy}, {32'd33, 1'b1, 1'b0});
    chk({tag, " dbz"}, 64'(dbz), 64'(m && a == 32'd0));
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset state", {result, valid, busy, div_by_zero}, '0);
    op_chk("mul 7*-3", 1'b0, 32'd7, -32'sd3);
    chk("mul 7*-3 literal", res, 64'hFFFFFFFF_FFFFFFEB);
    @(posedge clock); #1;
    chk("valid one pulse", {valid, div_by_zero}, '0);
    op_chk("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000);
    chk("mul min*min literal", res, 64'h40000000_00000000);
    op_chk("div -7/2", 1'b1, 32'd2, -32'sd7);
    chk("div -7/2 literal", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    op_chk("div ovf", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
    chk("div ovf literal", res, {32'h0, 32'h80000000});
    op_chk("div by zero", 1'b1, 32'd0, 32'd100);
    chk("div by zero literal", {res, dbz}, {32'h00000064, 32'hFFFFFFFF, 1'b1});
    @(posedge clock); #1;
    chk("dbz dropped", {valid, div_by_zero}, '0);
    op_chk("mul 5*6 ignore start", 1'b0, 32'd6, 32'd5);
    chk("mul 5*6 literal", res, 64'd30);
    op_chk("mul 9*9 back-to-back", 1'b0, 32'd9, 32'd9);
    chk("mul 9*9 literal", res, 64'd81);
    // abort an operation with reset at iteration 10
    start = 1'b1; muordi = 1'b0; opera1 = 32'd123; opera2 = 32'd456;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid-op reset", {result, valid, busy, div_by_zero}, '0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (valid || busy) saw_valid = 1'b1;
    end
    chk("no valid after abort", 64'(saw_valid), 64'd0);
    op_chk("after reset", 1'b1, -32'sd5, 32'd17);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic m;
      m = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'($urandom_range(0, 15)) - 32'd8;
        2: b = 32'h8000_0000;
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      op_chk("random", m, a, b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width in bits; legal values are even numbers from 4 to 64.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation; sampled only while busy=0.
REQ-005 SHALL have port muordi, input, 1 bit: operation select, sampled with start; 0 = multiply, 1 = divide.
REQ-006 SHALL have port opera1, input, WIDTH bits: signed multiplicand or divisor, sampled with start.
REQ-007 SHALL have port opera2, input, WIDTH bits: signed multiplier or dividend, sampled with start.
REQ-008 SHALL have port result, output, 2*WIDTH bits: the product, or {remainder, quotient} with the remainder in the upper half; held until the next accepted start.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse marking result as new.
REQ-010 SHALL have port busy, output, 1 bit: high from the accept edge until the edge that raises valid.
REQ-011 SHALL have port div_by_zero, output, 1 bit: qualified by valid; high for a divide with opera1 = 0.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and FIX; all outputs are registered.
REQ-013 On an edge in IDLE with start=1, SHALL capture muordi, the operand magnitudes and the operand signs, clear the iteration counter, set busy=1 and enter CALC.
REQ-014 On each edge in CALC, SHALL perform one iteration; after exactly WIDTH iterations it enters FIX.
- multiply: one shift-add step (add the multiplicand when the LSB is 1, then shift right).
- divide: one restoring shift-subtract step on a WIDTH+1-bit partial remainder.
REQ-015 On the FIX edge, SHALL apply the sign correction, load result, pulse valid=1, set busy=0 and return to IDLE.
- Sign correction uses two's-complement negation.
- Latency: valid is high in the cycle following edge N+WIDTH+1, where N is the accept edge.
REQ-016 Multiply SHALL produce the exact 2*WIDTH-bit signed product; opera1 = opera2 = -2^(WIDTH-1) yields +2^(2*WIDTH-2).
REQ-017 Divide SHALL truncate the quotient toward zero; the remainder takes the sign of the dividend (opera2), and |remainder| < |divisor|.
REQ-018 Divide by zero SHALL keep the same latency and return quotient = all ones, remainder = opera2, div_by_zero=1.
REQ-019 Divide overflow (-2^(WIDTH-1) / -1) SHALL return quotient = -2^(WIDTH-1), remainder = 0, div_by_zero=0.
REQ-020 start while busy=1 SHALL be ignored, and operand changes during an operation SHALL NOT affect the result.
REQ-021 start SHALL be accepted in the cycle in which valid=1, since the state is then IDLE; back-to-back operations therefore have a throughput of one per WIDTH+2 cycles.
REQ-022 div_by_zero SHALL be 0 whenever valid=0.

Reset
REQ-023 reset=1 on an edge SHALL force IDLE, result=0, valid=0, busy=0, div_by_zero=0 and counter=0, in any state, including mid-operation.
REQ-024 reset SHALL take priority over start on the same edge; no result is produced for an aborted operation.

Structure
REQ-025 SHALL take the state encoding (IDLE/CALC/FIX) and the mode constants (MODE_MUL=0, MODE_DIV=1) from the shared package muldiv_pkg.
REQ-026 SHALL instantiate one parametrised sub-module, add_rca_n: a WIDTH+1-bit ripple-carry adder/subtractor with carry-in, shared by both modes.
REQ-027 The counter SHALL be $clog2(WIDTH)+1 bits wide; no multiply or divide operators are allowed in the RTL.

Verification (WIDTH=32)
REQ-028 Multiply, opera1=7, opera2=-3 -> result=64'hFFFFFFFF_FFFFFFEB; valid is high exactly 33 cycles after the accept edge, and busy is high for those 33 cycles.
REQ-029 Multiply, opera1=opera2=32'h80000000 -> result=64'h40000000_00000000.
REQ-030 Divide, opera2=-7, opera1=2 -> result={32'hFFFFFFFF, 32'hFFFFFFFD}; divide, opera2=32'h80000000, opera1=32'hFFFFFFFF -> {32'h0, 32'h80000000}.
REQ-031 Divide, opera2=100, opera1=0 -> result={32'h00000064, 32'hFFFFFFFF} with div_by_zero=1 for the valid cycle only.
REQ-032 Start 5*6, then pulse start with new operands during CALC -> result=30 and the second start is ignored; then start 9*9 in the valid cycle -> 81 follows 34 cycles after the first valid.
REQ-033 Assert reset for 1 cycle at iteration 10 -> all outputs are 0, there is no valid pulse, and the next start completes correctly.
